song_reader: RTL and testbench

Sequential reader for the song ROM. It walks one song's 32 entries in order and fetches each `{note, duration}` word over the ROM's one-cycle registered read port. Each word is presented to the note player with a one-cycle `new_note` strobe, and the reader waits for the player's `note_done` before advancing. It sits between the song ROM and the note player, and tells the top-level control when a song has finished.

---
 rtl/song_reader.sv | 154 +++++++++++++++
 tb/tb_song_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// -----------------------------------------------------------------------------
// song_reader
// Walks the 32 entries of one song in the song ROM, fetching each
// {note, duration} word through the ROM's one-cycle registered read port,
// presenting it to the note player with a one-cycle new_note strobe, and
// waiting for the player's note_done before moving on. A word with a zero
// duration field marks the end of a song; reaching it (or finishing index 31)
// produces a one-cycle song_done pulse.
//
// Build option:
//   SONG_READER_LOOP_EN  defined   : after a song ends the reader returns to
//                                    IDLE and, with play held high, restarts
//                                    the song from index 0.
//                        undefined : after a song ends the reader parks in
//                                    STOPPED until play drops or song changes.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_play       1 = allowed to fetch new notes, 0 = hold between notes
//   i_song       song select
//   o_rom_addr   ROM address {song_q, idx}, combinational from registers
//   i_rom_dout   ROM word, [11:6] note, [5:0] duration, valid 1 cycle after addr
//   o_new_note   one-cycle strobe, o_note/o_duration valid with it
//   o_note       registered note code (0 = rest)
//   o_duration   registered duration
//   i_note_done  one-cycle pulse from the player when the note has elapsed
//   o_song_done  one-cycle pulse at the end of a song
// -----------------------------------------------------------------------------
module song_reader #(
  parameter int SONG_BITS  = 2,
  parameter int INDEX_BITS = 5
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_play,
  input  logic [SONG_BITS-1:0]            i_song,
  output logic [SONG_BITS+INDEX_BITS-1:0] o_rom_addr,
  input  logic [11:0]                     i_rom_dout,
  output logic                            o_new_note,
  output logic [5:0]                      o_note,
  output logic [5:0]                      o_duration,
  input  logic                            i_note_done,
  output logic                            o_song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_PLAYING,
    S_END
`ifdef SONG_READER_LOOP_EN
`else
    , S_STOPPED
`endif
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [INDEX_BITS-1:0] r_idx;
  logic [INDEX_BITS-1:0] w_idx_next;
  logic [SONG_BITS-1:0]  r_song_q;
  logic                  w_song_chg;
  logic                  w_capture;

  assign w_song_chg = (i_song != r_song_q);
  assign o_rom_addr = {r_song_q, r_idx};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_song_q   <= '0;
      o_note     <= '0;
      o_duration <= '0;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_song_q <= i_song;
      if (w_capture) begin
        o_note     <= i_rom_dout[11:6];
        o_duration <= i_rom_dout[5:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_capture    = 1'b0;
    o_new_note   = 1'b0;
    o_song_done  = 1'b0;
    // A song change overrides everything else in the same cycle, including
    // the strobes, a pending note_done and the end-of-song marker.
    if (w_song_chg) begin
      w_state_next = S_IDLE;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_play) w_state_next = S_FETCH;
        end
        S_FETCH: begin
          w_state_next = S_WAIT;
        end
        S_WAIT: begin
          // Zero duration is the end-of-song marker, never issued as a note.
          if (i_rom_dout[5:0] == 6'd0) begin
            w_state_next = S_END;
          end else begin
            w_capture    = 1'b1;
            w_state_next = S_ISSUE;
          end
        end
        S_ISSUE: begin
          o_new_note   = 1'b1;
          w_state_next = S_PLAYING;
        end
        S_PLAYING: begin
          if (i_note_done) begin
            if (r_idx == {INDEX_BITS{1'b1}}) begin
              w_state_next = S_END;
            end else begin
              w_idx_next   = r_idx + 1'b1;
              w_state_next = i_play ? S_FETCH : S_IDLE;
            end
          end
        end
        S_END: begin
          o_song_done = 1'b1;
          w_idx_next  = '0;
`ifdef SONG_READER_LOOP_EN
          w_state_next = S_IDLE;
`else
          w_state_next = S_STOPPED;
`endif
        end
`ifdef SONG_READER_LOOP_EN
`else
        S_STOPPED: begin
          // Leaving requires play to drop; a song change is handled above.
          if (!i_play) w_state_next = S_IDLE;
        end
`endif
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// -----------------------------------------------------------------------------
// tb_song_reader
// Directed walk through song_reader behaviour with a randomly filled ROM and
// random note_done spacing. Expected words come from the bench's own view of
// the current song and index; expected timing comes from the stated latencies.
// -----------------------------------------------------------------------------
module tb_song_reader;

  localparam int SB = 2;
  localparam int IB = 5;
  localparam int AW = SB + IB;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_play;
  logic [SB-1:0] i_song;
  logic [AW-1:0] o_rom_addr;
  logic [11:0]   i_rom_dout;
  logic          o_new_note;
  logic [5:0]    o_note;
  logic [5:0]    o_duration;
  logic          i_note_done;
  logic          o_song_done;

  song_reader #(.SONG_BITS(SB), .INDEX_BITS(IB)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_play      (i_play),
    .i_song      (i_song),
    .o_rom_addr  (o_rom_addr),
    .i_rom_dout  (i_rom_dout),
    .o_new_note  (o_new_note),
    .o_note      (o_note),
    .o_duration  (o_duration),
    .i_note_done (i_note_done),
    .o_song_done (o_song_done)
  );

  always #5 i_clk = ~i_clk;

  // Song ROM model with a registered read port.
  logic [11:0] mem [0:(1<<AW)-1];
  always @(posedge i_clk) i_rom_dout <= mem[o_rom_addr];

  int total = 0;
  int bad   = 0;
  int exp_song;
  int exp_idx;

  function automatic int cur_addr();
    return exp_song * (1 << IB) + exp_idx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_note_done = 1'b0;
  endtask

  // Expect new_note exactly n cycles from now carrying the word at the
  // bench's current song/index, with nothing issued in between.
  task automatic expect_issue(input string tag, input int n);
    logic [11:0] w;
    w = mem[cur_addr()];
    for (int k = 1; k <= n; k++) begin
      tick();
      chk({tag, "_addr"}, 32'(o_rom_addr), 32'(cur_addr()));
      chk({tag, "_sdone"}, 32'(o_song_done), 32'd0);
      if (k < n) begin
        chk({tag, "_early"}, 32'(o_new_note), 32'd0);
      end else begin
        chk({tag, "_nn"}, 32'(o_new_note), 32'd1);
        chk({tag, "_note"}, 32'(o_note), 32'(w[11:6]));
        chk({tag, "_dur"}, 32'(o_duration), 32'(w[5:0]));
      end
    end
    $display("issue %s song=%0d idx=%0d word=%03h", tag, exp_song, exp_idx, w);
  endtask

  // Advance n notes with random player delays, play held high.
  task automatic walk(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(1, 4)) begin
        tick();
        chk({tag, "_hold"}, 32'(o_new_note), 32'd0);
      end
      i_note_done = 1'b1;
      exp_idx++;
      expect_issue(tag, 3);
    end
  endtask

  // Song has ended without looping: nothing until play toggles low->high.
  task automatic expect_stopped(input string tag);
    repeat (5) begin
      tick();
      chk({tag, "_stopnn"}, 32'(o_new_note), 32'd0);
      chk({tag, "_stopsd"}, 32'(o_song_done), 32'd0);
    end
    i_play = 1'b0;
    tick();
    chk({tag, "_lownn"}, 32'(o_new_note), 32'd0);
    i_play = 1'b1;
    expect_issue({tag, "_restart"}, 3);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
    end
    mem[0]  = {6'd49, 6'd12};
    mem[1]  = {6'd1, 6'd8};
    mem[4]  = {6'd0, 6'd9};   // rest note
    mem[62] = {6'd0, 6'd0};   // song 1 end marker at index 30
    mem[64] = {6'd33, 6'd17};

    i_reset_n   = 1'b0;
    i_play      = 1'b1;
    i_song      = '0;
    i_note_done = 1'b0;
    exp_song    = 0;
    exp_idx     = 0;

    #1;
    chk("rst_addr", 32'(o_rom_addr), 32'd0);
    chk("rst_nn", 32'(o_new_note), 32'd0);
    chk("rst_note", 32'(o_note), 32'd0);
    chk("rst_dur", 32'(o_duration), 32'd0);
    chk("rst_sd", 32'(o_song_done), 32'd0);
    tick();
    tick();
    i_reset_n = 1'b1;
    chk("c0_nn", 32'(o_new_note), 32'd0);
    chk("c0_addr", 32'(o_rom_addr), 32'd0);
    expect_issue("first", 3);

    // Note-to-note latency.
    tick();
    i_note_done = 1'b1;
    exp_idx = 1;
    expect_issue("second", 3);

    // Play dropped: note_done goes to IDLE with idx advanced, no fetch.
    tick();
    i_play      = 1'b0;
    i_note_done = 1'b1;
    exp_idx     = 2;
    tick();
    chk("idle_addr", 32'(o_rom_addr), 32'(cur_addr()));
    i_note_done = 1'b1;  // ignored outside PLAYING
    repeat (3) begin
      tick();
      chk("idle_nn", 32'(o_new_note), 32'd0);
      chk("idle_addr2", 32'(o_rom_addr), 32'(cur_addr()));
    end
    i_play = 1'b1;
    expect_issue("resume", 3);

    // Walk to index 7, then change song together with note_done.
    walk("walk0", 5);
    tick();
    i_song      = 2'd1;
    i_note_done = 1'b1;
    exp_song    = 1;
    exp_idx     = 0;
    tick();
    chk("chg_addr", 32'(o_rom_addr), 32'd32);
    chk("chg_sd", 32'(o_song_done), 32'd0);
    chk("chg_nn", 32'(o_new_note), 32'd0);
    expect_issue("chg", 3);

    // Walk song 1 to index 29; the next word is the end marker.
    walk("walk1", 29);
    tick();
    i_note_done = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("mark_nn", 32'(o_new_note), 32'd0);
      chk("mark_sd", 32'(o_song_done), (k == 3) ? 32'd1 : 32'd0);
    end
    exp_idx = 0;
    tick();
    chk("mark_sd_off", 32'(o_song_done), 32'd0);
    chk("mark_addr", 32'(o_rom_addr), 32'(cur_addr()));
    chk("mark_nn2", 32'(o_new_note), 32'd0);
`ifdef SONG_READER_LOOP_EN
    expect_issue("mark_loop", 3);
`else
    expect_stopped("mark");
`endif

    // Switch to song 2 (no end marker) and play through index 31.
    tick();
    i_song   = 2'd2;
    exp_song = 2;
    exp_idx  = 0;
    tick();
    chk("chg2_addr", 32'(o_rom_addr), 32'd64);
    expect_issue("chg2", 3);
    walk("walk2", 31);
    tick();
    i_note_done = 1'b1;
    exp_idx     = 0;
    tick();
    chk("last_sd", 32'(o_song_done), 32'd1);
    chk("last_nn", 32'(o_new_note), 32'd0);
`ifdef SONG_READER_LOOP_EN
    expect_issue("last_loop", 4);
`else
    expect_stopped("last");
`endif

    // Asynchronous reset in the middle of a note.
    tick();
    tick();
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("arst_addr", 32'(o_rom_addr), 32'd0);
    chk("arst_note", 32'(o_note), 32'd0);
    chk("arst_dur", 32'(o_duration), 32'd0);
    chk("arst_nn", 32'(o_new_note), 32'd0);
    chk("arst_sd", 32'(o_song_done), 32'd0);
    i_song = 2'd0;
    tick();
    i_reset_n = 1'b1;
    exp_song  = 0;
    exp_idx   = 0;
    expect_issue("post_rst", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
